// File: rtl/prog_line_fetcher.sv
// prog_line_fetcher: refills 2 KiB program regions into a small line FIFO using single-word reads.
// Define PROG_FETCH_STATS_EN to add the stat_regions / stat_stall_cycles counters.
module prog_line_fetcher #(
  parameter int FIFO_DEPTH    = 4,
  parameter int LINE_WIDTH    = 512,
  parameter int LINES_PER_REQ = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  is_req,
  input  logic [20:0]           req_addr,
  input  logic                  is_read,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [6:0]            fifo_addr,
  output logic [LINE_WIDTH-1:0] read_line_data,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  busy
`ifdef PROG_FETCH_STATS_EN
  ,
  output logic [15:0]           stat_regions,
  output logic [31:0]           stat_stall_cycles
`endif
);

  localparam int WORDS_PER_LINE = LINE_WIDTH / 32;
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNT_W          = PTR_W + 1;

  localparam logic [3:0]       LAST_WORD  = 4'(WORDS_PER_LINE - 1);
  localparam logic [4:0]       LAST_LINE  = 5'(LINES_PER_REQ - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PUSH,
    S_DRAIN,
    S_HOLD
  } state_e;

  state_e state_q, state_d;

  logic [20:0] region_q, region_d;
  logic [4:0]  line_q, line_d;
  logic [3:0]  word_q, word_d;
  logic        hold_q, hold_d;

  logic [LINE_WIDTH-1:0] asm_q;

  logic [LINE_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [6:0]            fifo_tag_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic pop_en;
  logic push_en;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept the pending line.
  assign pop_en  = is_read & (count_q != '0);
  assign push_en = (state_q == S_PUSH) & ((count_q != FULL_COUNT) | pop_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (is_req) state_d = S_ISSUE;
      S_ISSUE: if (mem_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = (word_q == LAST_WORD) ? S_PUSH : S_ISSUE;
        end
      end
      S_PUSH: begin
        if (push_en) begin
          state_d = (line_q == LAST_LINE) ? S_DRAIN : S_ISSUE;
        end
      end
      S_DRAIN: if (count_q == '0) state_d = S_HOLD;
      S_HOLD:  if (hold_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req        = (state_q == S_ISSUE);
    busy           = (state_q != S_IDLE);
    fifo_empty     = (count_q == '0);
    fifo_full      = (count_q == FULL_COUNT) | ((state_q == S_DRAIN) & (count_q != '0));
    fifo_addr      = (count_q == '0) ? 7'd0 : fifo_tag_q[rd_ptr_q];
    read_line_data = (count_q == '0) ? '0 : fifo_data_q[rd_ptr_q];
    mem_addr       = {region_q, line_q, word_q, 2'b00};
  end

  always_comb begin
    region_d = region_q;
    line_d   = line_q;
    word_d   = word_q;
    hold_d   = hold_q;
    case (state_q)
      S_IDLE: begin
        if (is_req) begin
          region_d = req_addr;
          line_d   = '0;
          word_d   = '0;
        end
      end
      S_WAIT: begin
        if (mem_rvalid && (word_q != LAST_WORD)) begin
          word_d = word_q + 4'd1;
        end
      end
      S_PUSH: begin
        if (push_en && (line_q != LAST_LINE)) begin
          line_d = line_q + 5'd1;
          word_d = '0;
        end
      end
      S_DRAIN: hold_d = 1'b0;
      S_HOLD:  hold_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      region_q <= '0;
      line_q   <= '0;
      word_q   <= '0;
      hold_q   <= 1'b0;
      asm_q    <= '0;
    end else begin
      region_q <= region_d;
      line_q   <= line_d;
      word_q   <= word_d;
      hold_q   <= hold_d;
      if ((state_q == S_WAIT) && mem_rvalid) begin
        asm_q[32*int'(word_q) +: 32] <= mem_rdata;
      end
    end
  end

  // Line storage is not reset; the head outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_data_q[wr_ptr_q] <= asm_q;
      fifo_tag_q[wr_ptr_q]  <= {region_q[1:0], line_q};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_en && !pop_en) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop_en && !push_en) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

`ifdef PROG_FETCH_STATS_EN
  logic [15:0] stat_regions_q;
  logic [31:0] stat_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_regions_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      if ((state_q == S_DRAIN) && (state_d == S_HOLD)) begin
        stat_regions_q <= stat_regions_q + 16'd1;
      end
      if ((state_q == S_PUSH) && (count_q == FULL_COUNT)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_regions      = stat_regions_q;
  assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: doc/prog_line_fetcher.md
# prog_line_fetcher

Refill engine upstream of the program cache. Accepts a 2 KiB region request (`is_req`/`req_addr`), fetches the region's 32 lines of 512 bits as single-word reads on a 32-bit memory port, and queues them in a small line FIFO. The cache pops the FIFO with `is_read`, and `fifo_addr` tells it the destination line.

## Interface
- `FIFO_DEPTH`, 4: line FIFO entries; power of two, ≥2.
- `LINE_WIDTH`, 512: line width in bits; fixed at 16 words.
- `LINES_PER_REQ`, 32: lines per region.

Ports:
- `clk` in 1: the block's single clock.
- `reset` in 1: synchronous, active-high.
- `is_req` in 1: region request, level; sampled in IDLE only.
- `req_addr` in 21: region address, `addr[31:11]`.
- `is_read` in 1: pop head line; ignored when `fifo_empty`.
- `fifo_empty` out 1: FIFO holds no line.
- `fifo_full` out 1: drain indicator, defined in Operation.
- `fifo_addr` out 7: head line index `{region[1:0], line[4:0]}`.
- `read_line_data` out 512: head line; word k occupies bits `[32k+31:32k]`.
- `mem_req` out 1: read request valid.
- `mem_addr` out 32: word address, `{region, line[4:0], word[3:0], 2'b00}`.
- `mem_ready` in 1: request accepted this cycle (`mem_req & mem_ready`).
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read data.
- `busy` out 1: high in every state except IDLE.

## Operation
- **IDLE**: if `is_req`, latch `region <= req_addr`, clear line and word counters, go to ISSUE.
- **ISSUE**: hold `mem_req=1` with a stable `mem_addr` until `mem_ready`, then go to WAIT.
- **WAIT**: on `mem_rvalid`, write `mem_rdata` into assembly word `word`.
  - If `word != 15`: increment `word`, go to ISSUE.
  - If `word == 15`: go to PUSH.
- Only one read is outstanding at a time. `mem_rvalid` outside WAIT is ignored.
- **PUSH**: enqueue the assembled line tagged `{region[1:0], line}` when the FIFO is not full (count below `FIFO_DEPTH`); otherwise stall in PUSH.
  - On enqueue, if `line != 31`: increment `line`, reset `word`, go to ISSUE.
  - On enqueue, if `line == 31`: go to DRAIN.
- **DRAIN**: wait until `fifo_empty`, then go to HOLD.
- **HOLD**: stay exactly 2 cycles, then go to IDLE. This window lets the cache's miss logic clear so the same region is not re-fetched.
- `fifo_full` = (count == `FIFO_DEPTH`) | ((state == DRAIN) & ~`fifo_empty`).
- FIFO behaviour:
  - Pointers are `log2(FIFO_DEPTH)` bits and wrap naturally.
  - A simultaneous push and pop leaves count unchanged and is legal when full, because the pop frees the slot in the same cycle.
  - A pop while empty is a no-op.
- `is_req` outside IDLE is ignored; no request queueing.
- Counter widths: `word` is 4 bits, `line` is 5 bits. Address concatenation is exact, with no carry into `region`.

## Timing
- All outputs are registered or decoded from registered state. No combinational path runs from `is_read`, `mem_ready` or `mem_rvalid` to any output.
- Reset values:
  - `fifo_empty=1`, `fifo_full=0`, `mem_req=0`, `busy=0`.
  - `fifo_addr=0`, `read_line_data=0`, `mem_addr=0`.
  - State IDLE, FIFO count 0.
- Reset mid-fetch aborts immediately. Any outstanding `mem_rvalid` after reset is ignored, since the block is in IDLE.
- `is_req` high in IDLE at edge N gives `mem_req=1` at N+1.
- With zero-wait memory (`mem_ready` always high, `mem_rvalid` one cycle after accept), each word takes 2 cycles and each line takes 33 cycles including PUSH.
- A pushed line is visible at the FIFO head (`fifo_empty=0`) on the cycle after the PUSH edge.
- Head data and `fifo_addr` are valid whenever `fifo_empty=0` and change only after a pop.

## Configuration
- `PROG_FETCH_STATS_EN` defined adds two outputs; neither saturates, and both are cleared by reset:
  - `stat_regions[15:0]`: completed regions, counted on DRAIN→HOLD.
  - `stat_stall_cycles[31:0]`: cycles spent in PUSH with the FIFO full.
- `PROG_FETCH_STATS_EN` undefined: both ports and all counters are absent. Behaviour is otherwise identical.

## Test plan
- Zero-wait memory, `is_req=1`, `req_addr=21'h00_0003`, `is_read` tied high:
  - First `mem_addr` is `0x00001800`, the last is `0x00001FFC`.
  - 32 lines are popped with `fifo_addr` running `0x60..0x7F`.
  - Memory returns data equal to its address; line 0 word 5 reads `0x00001814`.
- `is_read` tied low, `FIFO_DEPTH=4`: `fifo_full=1` after 4 lines, and `mem_req` stays 0 while stalled in PUSH. Popping one line lets the fetch resume within 2 cycles.
- Simultaneous push and pop with the FIFO full: count stays 4, and no line is lost or duplicated; check the sequence of 32 distinct `fifo_addr` values.
- `mem_ready` held low for 7 cycles: `mem_req` and `mem_addr` stay stable throughout, and exactly one request is accepted.
- `reset` asserted during line 10: the next cycle shows IDLE, `fifo_empty=1` and `mem_req=0`. A new request then restarts at line 0.
- `is_req` held high throughout a region: the block sees DRAIN, then 2 HOLD cycles, then re-latches in IDLE. `stat_regions` increments by 1 per region when `PROG_FETCH_STATS_EN` is defined.
